deadlock_block_aggregator: RTL and testbench
============================================

Name: deadlock_block_aggregator

Overview:
- Cosim-side stage directly downstream of the per-instance deadlock monitors.
- Collects their registered `block` outputs, together with design-level progress and idle indications.
- Qualifies a persistent stall with a consecutive-cycle threshold, then latches a sticky deadlock verdict with a snapshot for the testbench to report.
- Pure synchronous RTL; one clock domain.

Parameters:
- N_MON, 4: number of monitor `block` inputs.
- IDX_W, 2: width of the index output; must satisfy 2^IDX_W >= N_MON.
- THRESH, 1024: consecutive blocked cycles required to declare deadlock; legal range 1 .. 2^CNT_W-1.
- CNT_W, 16: stall counter width.
- STAMP_W, 32: free-running cycle stamp width.

Ports:
- clock, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- block_sigs, input, N_MON: `block` outputs of the monitors; bit i = monitor i.
- progress, input, 1: any stream/handshake transfer fired this cycle.
- all_idle, input, 1: design idle/finished.
- clear, input, 1: one-cycle pulse; rearms the detector.
- deadlock, output, 1: sticky verdict.
- deadlock_mask, output, N_MON: block_sigs snapshot at trigger.
- deadlock_first_idx, output, IDX_W: lowest set bit index of deadlock_mask.
- deadlock_stamp, output, STAMP_W: cycle stamp at trigger.
- stall_count, output, CNT_W: current consecutive blocked count.
- max_stall, output, CNT_W: longest stall run (optional feature).

Behaviour:
- Reset values: every output 0; state IDLE; cycle stamp 0.
- Cycle stamp:
  - Increments every cycle after reset; saturates at all-ones.
  - Not affected by clear.
- blocked term: blocked = (|block_sigs) & ~progress & ~all_idle.
- State IDLE:
  - blocked=1 -> STALL, stall_count <= 1.
  - Otherwise stall_count stays 0.
- State STALL:
  - blocked=0 -> IDLE, stall_count <= 0.
  - blocked=1 and stall_count+1 < THRESH -> stall_count increments.
  - blocked=1 and stall_count+1 == THRESH -> DEADLOCK.
- Trigger edge (into DEADLOCK, or THRESH=1 direct from IDLE on first blocked sample):
  - deadlock <= 1.
  - deadlock_mask <= block_sigs as sampled that edge.
  - deadlock_first_idx <= lowest set index of that sample.
  - deadlock_stamp <= cycle stamp value before increment.
  - stall_count <= THRESH.
- Latency: deadlock rises on the edge sampling the THRESH-th consecutive blocked cycle. With block held from sample edge k, deadlock is visible after edge k+THRESH-1.
- State DEADLOCK:
  - Sticky; ignores block_sigs, progress and all_idle.
  - All snapshot outputs held; stall_count frozen.
- clear (any state) -> IDLE next edge:
  - Zeroes deadlock, mask, first_idx, stamp and stall_count.
  - clear has priority over a trigger on the same edge: no deadlock.
  - The blocked sample on the clear edge is discarded, so counting restarts on the following edge.
- progress or all_idle on any cycle in STALL fully restarts the count (no partial credit).
- block_sigs bits that go 0 then 1 across cycles still count as continuous as long as at least one bit is 1 each cycle.
- reset mid-operation: identical to power-on reset in all states, including DEADLOCK.
- Bits of deadlock_first_idx above the needed width are 0.

Optional Feature:
- Macro: DEADLOCK_MAX_STALL_EN.
- Defined:
  - max_stall register tracks max(max_stall, stall_count), updated every edge in STALL and on trigger.
  - Survives clear; zeroed only by reset.
- Undefined: max_stall is constant 0 and no register is inferred. All other behaviour is identical.

Test Plan (THRESH=8, N_MON=4):
- Reset with all inputs 0 -> all outputs 0; stall_count remains 0 for 20 cycles.
- block_sigs=4'b0110 held, progress=0 -> deadlock rises after the 8th blocked edge; mask=0110, first_idx=1, stall_count=8. It stays set after block_sigs returns to 0.
- block_sigs=4'b1000 for 7 cycles, then progress=1 for 1 cycle, then 7 more blocked cycles -> no deadlock; stall_count peaks at 7, and max_stall=7 with the macro defined.
- all_idle=1 during an otherwise blocked run -> stall_count returns to 0, no deadlock.
- clear pulsed on the same edge as the 8th blocked sample -> deadlock stays 0, stall_count=0; continued blocking triggers 8 edges later.
- Deadlock latched, then reset asserted for 1 cycle -> all outputs 0, including max_stall and deadlock_stamp.

Source files
------------

// File: rtl/deadlock_block_aggregator.sv
`default_nettype none
// ============================================================================
//  Module      : deadlock_block_aggregator
//  Description : Collects the registered block outputs of the per-instance
//                deadlock monitors. A stall is qualified only when some
//                monitor is blocked while the design makes no progress and
//                is not idle. After THRESH consecutive qualified cycles a
//                sticky deadlock verdict is latched, together with a snapshot
//                of the monitor mask, its lowest set index and a cycle stamp.
//                Optional feature macro: DEADLOCK_MAX_STALL_EN (records the
//                longest stall run; survives clear, zeroed by reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module deadlock_block_aggregator #(
    parameter int N_MON   = 4,
    parameter int IDX_W   = 2,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16,
    parameter int STAMP_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_MON-1:0]   block_sigs,
    input  logic               progress,
    input  logic               all_idle,
    input  logic               clear,
    output logic               deadlock,
    output logic [N_MON-1:0]   deadlock_mask,
    output logic [IDX_W-1:0]   deadlock_first_idx,
    output logic [STAMP_W-1:0] deadlock_stamp,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   max_stall
);

    // Threshold expressed at counter width; one extra bit for the compare so
    // that stall_count + 1 can never wrap before it is tested.
    localparam logic [CNT_W-1:0] c_THRESH_CNT = CNT_W'(THRESH);
    localparam logic [CNT_W:0]   c_THRESH_EXT = {1'b0, c_THRESH_CNT};
    localparam logic [CNT_W:0]   c_ONE_EXT    = {{CNT_W{1'b0}}, 1'b1};
    localparam bit               c_THRESH_ONE = (THRESH == 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STALL    = 2'd1,
        S_DEADLOCK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_stall_count;
    logic [CNT_W-1:0]     w_count_next;
    logic [CNT_W:0]       w_count_inc;
    logic                 w_blocked;
    logic                 w_trigger;
    logic [IDX_W-1:0]     w_first_idx;
    logic [STAMP_W-1:0]   r_stamp;
    logic                 r_deadlock;
    logic [N_MON-1:0]     r_mask;
    logic [IDX_W-1:0]     r_first_idx;
    logic [STAMP_W-1:0]   r_dl_stamp;

    // A cycle counts as stalled only if something is blocked, nothing moved
    // and the design has not already finished.
    assign w_blocked   = (|block_sigs) & ~progress & ~all_idle;
    assign w_count_inc = {1'b0, r_stall_count} + c_ONE_EXT;

    // Lowest set monitor index of the current sample; scanning from the top
    // lets the lowest hit overwrite the others. Unused upper bits stay 0.
    always_comb begin
        w_first_idx = '0;
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (block_sigs[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    // Free-running cycle stamp, saturating; clear deliberately leaves it alone
    // so stamps stay comparable across rearms.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stamp <= '0;
        end else if (r_stamp != {STAMP_W{1'b1}}) begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    // Next-state and stall counter logic; clear overrides everything,
    // including a trigger on the same edge, and discards that blocked sample.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_stall_count;
        w_trigger    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_blocked) begin
                    if (c_THRESH_ONE) begin
                        w_trigger    = 1'b1;
                        w_state_next = S_DEADLOCK;
                        w_count_next = c_THRESH_CNT;
                    end else begin
                        w_state_next = S_STALL;
                        w_count_next = CNT_W'(1);
                    end
                end else begin
                    w_count_next = '0;
                end
            end
            S_STALL: begin
                if (!w_blocked) begin
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                end else if (w_count_inc >= c_THRESH_EXT) begin
                    w_trigger    = 1'b1;
                    w_state_next = S_DEADLOCK;
                    w_count_next = c_THRESH_CNT;
                end else begin
                    w_count_next = w_count_inc[CNT_W-1:0];
                end
            end
            S_DEADLOCK: begin
                w_state_next = S_DEADLOCK;
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
        if (clear) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
            w_trigger    = 1'b0;
        end
    end

    // State and stall counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_stall_count <= w_count_next;
        end
    end

    // Sticky verdict and snapshot: loaded once on the trigger edge, held
    // until clear or reset.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_deadlock  <= 1'b0;
            r_mask      <= '0;
            r_first_idx <= '0;
            r_dl_stamp  <= '0;
        end else if (w_trigger) begin
            r_deadlock  <= 1'b1;
            r_mask      <= block_sigs;
            r_first_idx <= w_first_idx;
            r_dl_stamp  <= r_stamp;
        end
    end

`ifdef DEADLOCK_MAX_STALL_EN
    logic [CNT_W-1:0] r_max_stall;

    // High-water mark of the stall counter; tracking the next count covers
    // both the counting edges and the trigger edge (count becomes THRESH).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_max_stall <= '0;
        end else if (w_count_next > r_max_stall) begin
            r_max_stall <= w_count_next;
        end
    end

    assign max_stall = r_max_stall;
`else
    assign max_stall = '0;
`endif

    assign deadlock           = r_deadlock;
    assign deadlock_mask      = r_mask;
    assign deadlock_first_idx = r_first_idx;
    assign deadlock_stamp     = r_dl_stamp;
    assign stall_count        = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_deadlock_block_aggregator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deadlock_block_aggregator
//  Description : Self-checking bench for deadlock_block_aggregator with
//                THRESH=8, N_MON=4. A run-length reference model predicts all
//                outputs every cycle; directed sequences pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deadlock_block_aggregator;

    localparam int N_MON   = 4;
    localparam int IDX_W   = 2;
    localparam int THRESH  = 8;
    localparam int CNT_W   = 16;
    localparam int STAMP_W = 32;

    logic               clock;
    logic               reset;
    logic [N_MON-1:0]   block_sigs;
    logic               progress;
    logic               all_idle;
    logic               clear;
    logic               deadlock;
    logic [N_MON-1:0]   deadlock_mask;
    logic [IDX_W-1:0]   deadlock_first_idx;
    logic [STAMP_W-1:0] deadlock_stamp;
    logic [CNT_W-1:0]   stall_count;
    logic [CNT_W-1:0]   max_stall;

    int n_checks = 0;
    int n_errors = 0;

    deadlock_block_aggregator #(
        .N_MON   (N_MON),
        .IDX_W   (IDX_W),
        .THRESH  (THRESH),
        .CNT_W   (CNT_W),
        .STAMP_W (STAMP_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .block_sigs         (block_sigs),
        .progress           (progress),
        .all_idle           (all_idle),
        .clear              (clear),
        .deadlock           (deadlock),
        .deadlock_mask      (deadlock_mask),
        .deadlock_first_idx (deadlock_first_idx),
        .deadlock_stamp     (deadlock_stamp),
        .stall_count        (stall_count),
        .max_stall          (max_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // The model thinks in terms of "length of the current run of stalled
    // samples" plus a sticky verdict, rather than states.
    bit          m_valid = 1'b0;
    bit          m_dl;
    bit [3:0]    m_mask;
    int          m_idx;
    longint      m_stamp;
    longint      m_cycle;   // cycle stamp before this edge
    int          m_run;
    int          m_max;

    bit          t_dl;
    bit [3:0]    t_mask;
    int          t_idx;
    longint      t_stamp;
    int          t_run;
    int          t_max;

    function automatic int lowest_bit(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_dl    <= 1'b0;
            m_mask  <= '0;
            m_idx   <= 0;
            m_stamp <= 0;
            m_cycle <= 0;
            m_run   <= 0;
            m_max   <= 0;
        end else if (m_valid) begin
            t_dl = m_dl; t_mask = m_mask; t_idx = m_idx;
            t_stamp = m_stamp; t_run = m_run; t_max = m_max;
            if (clear) begin
                t_dl = 1'b0; t_mask = '0; t_idx = 0; t_stamp = 0; t_run = 0;
            end else if (!t_dl) begin
                if (block_sigs != 0 && !progress && !all_idle) begin
                    t_run = t_run + 1;
                    if (t_run == THRESH) begin
                        t_dl    = 1'b1;
                        t_mask  = block_sigs;
                        t_idx   = lowest_bit(block_sigs);
                        t_stamp = m_cycle;
                    end
                end else begin
                    t_run = 0;
                end
            end
            if (t_run > t_max) t_max = t_run;
            m_dl    <= t_dl;
            m_mask  <= t_mask;
            m_idx   <= t_idx;
            m_stamp <= t_stamp;
            m_run   <= t_run;
            m_max   <= t_max;
            m_cycle <= (m_cycle == 64'hFFFF_FFFF) ? m_cycle : m_cycle + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("model.deadlock", longint'(deadlock),           longint'(m_dl));
            check("model.mask",     longint'(deadlock_mask),      longint'(m_mask));
            check("model.idx",      longint'(deadlock_first_idx), longint'(m_idx));
            check("model.stamp",    longint'(deadlock_stamp),     m_stamp);
            check("model.count",    longint'(stall_count),        longint'(m_run));
`ifdef DEADLOCK_MAX_STALL_EN
            check("model.max",      longint'(max_stall),          longint'(m_max));
`else
            check("model.max",      longint'(max_stall),          0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [3:0] bs, input logic pr, input logic id,
                         input logic cl, input logic rs);
        block_sigs = bs;
        progress   = pr;
        all_idle   = id;
        clear      = cl;
        reset      = rs;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_n(input int n, input logic [3:0] bs, input logic pr,
                           input logic id);
        for (int i = 0; i < n; i++) apply(bs, pr, id, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".deadlock"}, longint'(deadlock), 0);
        check({tag, ".mask"},     longint'(deadlock_mask), 0);
        check({tag, ".stamp"},    longint'(deadlock_stamp), 0);
        check({tag, ".count"},    longint'(stall_count), 0);
        check({tag, ".max"},      longint'(max_stall), 0);
    endtask

    initial begin
        block_sigs = '0; progress = 1'b0; all_idle = 1'b0;
        clear = 1'b0; reset = 1'b1;
        apply(4'b0000, 0, 0, 0, 1);
        apply(4'b0000, 0, 0, 0, 1);
        check_zero("reset");

        // Quiet inputs: nothing counts.
        apply_n(20, 4'b0000, 0, 0);
        check("quiet.count", longint'(stall_count), 0);
        check("quiet.deadlock", longint'(deadlock), 0);

        // Held block: trigger on the 8th blocked edge (edge 28 after reset).
        apply_n(7, 4'b0110, 0, 0);
        check("hold7.deadlock", longint'(deadlock), 0);
        check("hold7.count", longint'(stall_count), 7);
        apply_n(1, 4'b0110, 0, 0);
        check("hold8.deadlock", longint'(deadlock), 1);
        check("hold8.mask", longint'(deadlock_mask), 6);
        check("hold8.idx", longint'(deadlock_first_idx), 1);
        check("hold8.count", longint'(stall_count), 8);
        check("hold8.stamp", longint'(deadlock_stamp), 27);
        apply_n(3, 4'b0000, 1, 1);
        check("sticky.deadlock", longint'(deadlock), 1);
        check("sticky.mask", longint'(deadlock_mask), 6);
        check("sticky.count", longint'(stall_count), 8);

        // Reset while in deadlock behaves like power-on.
        apply(4'b0000, 0, 0, 0, 1);
        check_zero("midreset");

        // Progress breaks a run: two runs of 7, no deadlock.
        apply_n(7, 4'b1000, 0, 0);
        check("run7.count", longint'(stall_count), 7);
        apply_n(1, 4'b1000, 1, 0);
        check("progress.count", longint'(stall_count), 0);
        apply_n(7, 4'b1000, 0, 0);
        check("run7b.count", longint'(stall_count), 7);
        check("run7b.deadlock", longint'(deadlock), 0);
`ifdef DEADLOCK_MAX_STALL_EN
        check("run7b.max", longint'(max_stall), 7);
`endif
        apply_n(1, 4'b0000, 0, 0);

        // all_idle restarts the count.
        apply_n(5, 4'b0011, 0, 0);
        apply_n(1, 4'b0011, 0, 1);
        check("idle.count", longint'(stall_count), 0);
        apply_n(5, 4'b0100, 0, 0);
        check("idle5.count", longint'(stall_count), 5);
        check("idle5.deadlock", longint'(deadlock), 0);
        apply_n(1, 4'b0000, 0, 0);

        // Clear on the 8th blocked sample wins; counting restarts afterwards.
        apply_n(7, 4'b0101, 0, 0);
        apply(4'b0101, 0, 0, 1, 0);
        check("clr8.deadlock", longint'(deadlock), 0);
        check("clr8.count", longint'(stall_count), 0);
        apply_n(7, 4'b0101, 0, 0);
        check("clr15.deadlock", longint'(deadlock), 0);
        apply_n(1, 4'b1100, 0, 0);
        check("clr16.deadlock", longint'(deadlock), 1);
        check("clr16.mask", longint'(deadlock_mask), 12);
        check("clr16.idx", longint'(deadlock_first_idx), 2);

        // Randomised phase, checked cycle-by-cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] bs;
            bs = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 15)) : 4'b0000;
            apply(bs,
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 999) == 0));
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
